// File: rtl/cp_loop_pkg.sv
// rtl/cp_loop_pkg.sv - shared types, defaults and clamp helper for the PLL loop filter
//
// Purpose : FSM state encoding, default parameter values and the saturating
//           clamp used by the error counter, the integrator and the control word.
// Ports   : none (package).
// Config  : CP_LOCK_DETECT_EN is consumed by cp_loop_filter, not by this package.

package cp_loop_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_UPDATE  = 2'd2
  } cp_state_t;

  localparam int DEF_CTRL_W    = 12;
  localparam int DEF_PW        = 8;
  localparam int DEF_KP_SHIFT  = 2;
  localparam int DEF_KI_SHIFT  = 4;
  localparam int DEF_CTRL_INIT = 2048;
  localparam int DEF_LOCK_TOL  = 2;
  localparam int DEF_LOCK_CNT  = 16;

  // Signed clamp of v into [lo, hi].
  function automatic int clamp_int(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/pfd_sync.sv
// rtl/pfd_sync.sv - two-flop synchronizer for one PFD pulse line
//
// Purpose : brings an asynchronous PFD pulse into the clk domain.
// Ports   : clk   - sampling clock
//           reset - synchronous active-high, clears both flops
//           d     - asynchronous input
//           q     - synchronized output, two cycles after d
// Config  : none.

module pfd_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/cp_loop_filter.sv
// rtl/cp_loop_filter.sv - digital charge pump and PI loop filter driving the DCO word
//
// Purpose : measures each up/dn pulse window as a signed cycle count, integrates
//           it with anti-windup and produces a clamped DCO control word.
// Ports   : clk, reset (sync, active-high)
//           up, dn       - asynchronous PFD pulses
//           ctrl         - DCO control word, held between strobes
//           ctrl_valid   - one-cycle strobe when ctrl is updated
//           err          - signed count of the last completed window
//           sat_hi/lo    - last update clamped at max / min
//           locked       - lock indicator
// Config  : define CP_LOCK_DETECT_EN to build the lock detector; otherwise
//           locked is tied low.

module cp_loop_filter
  import cp_loop_pkg::*;
#(
  parameter int CTRL_W    = DEF_CTRL_W,
  parameter int PW        = DEF_PW,
  parameter int KP_SHIFT  = DEF_KP_SHIFT,
  parameter int KI_SHIFT  = DEF_KI_SHIFT,
  parameter int CTRL_INIT = DEF_CTRL_INIT,
  parameter int LOCK_TOL  = DEF_LOCK_TOL,
  parameter int LOCK_CNT  = DEF_LOCK_CNT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 up,
  input  logic                 dn,
  output logic [CTRL_W-1:0]    ctrl,
  output logic                 ctrl_valid,
  output logic signed [PW-1:0] err,
  output logic                 sat_hi,
  output logic                 sat_lo,
  output logic                 locked
);

  localparam int GW        = CTRL_W + KI_SHIFT;
  localparam int IW        = CTRL_W + KI_SHIFT + 2;
  localparam int CNT_MAX   = (1 << (PW - 1)) - 1;
  localparam int CTRL_MAX  = (1 << CTRL_W) - 1;
  localparam int INTEG_MAX = CTRL_MAX << KI_SHIFT;

  logic up_s, dn_s;

  pfd_sync u_sync_up (.clk(clk), .reset(reset), .d(up), .q(up_s));
  pfd_sync u_sync_dn (.clk(clk), .reset(reset), .d(dn), .q(dn_s));

  cp_state_t state, state_nxt;
  logic start_win, step_win, close_win, do_update;

  logic signed [PW-1:0] cnt;
  logic [GW-1:0]        integ;
  logic signed [IW-1:0] integ_new;
  logic signed [IW-1:0] ctrl_sum;
  int                   delta;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (up_s || dn_s)    state_nxt = ST_MEASURE;
      ST_MEASURE: if (!(up_s || dn_s)) state_nxt = ST_UPDATE;
      ST_UPDATE:                       state_nxt = ST_IDLE;
      default:                         state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    start_win = 1'b0;
    step_win  = 1'b0;
    close_win = 1'b0;
    do_update = 1'b0;
    case (state)
      ST_IDLE:    start_win = up_s | dn_s;
      ST_MEASURE: begin
        step_win  = up_s | dn_s;
        close_win = ~(up_s | dn_s);
      end
      ST_UPDATE:  do_update = 1'b1;
      default:    ;
    endcase
  end

  // Both lines high is a neutral cycle: it extends the window without counting.
  always_comb begin
    delta = 0;
    if (up_s && !dn_s)      delta = 1;
    else if (dn_s && !up_s) delta = -1;
  end

  // Integrator with anti-windup, then proportional path added on the integer part.
  always_comb begin
    integ_new = IW'(clamp_int(int'(integ) + int'(err), 0, INTEG_MAX));
    ctrl_sum  = IW'((int'(integ_new) >>> KI_SHIFT) + int'(err) * (1 << KP_SHIFT));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      err        <= '0;
      integ      <= GW'(CTRL_INIT << KI_SHIFT);
      ctrl       <= CTRL_W'(CTRL_INIT);
      ctrl_valid <= 1'b0;
      sat_hi     <= 1'b0;
      sat_lo     <= 1'b0;
    end else begin
      ctrl_valid <= do_update;
      if (start_win)
        cnt <= PW'(delta);
      else if (step_win)
        cnt <= PW'(clamp_int(int'(cnt) + delta, -CNT_MAX, CNT_MAX));
      if (close_win)
        err <= cnt;
      if (do_update) begin
        integ  <= GW'(integ_new);
        ctrl   <= CTRL_W'(clamp_int(int'(ctrl_sum), 0, CTRL_MAX));
        sat_hi <= int'(ctrl_sum) > CTRL_MAX;
        sat_lo <= ctrl_sum < 0;
      end
    end
  end

`ifdef CP_LOCK_DETECT_EN
  localparam int LCW = $clog2(LOCK_CNT + 1);

  logic [LCW-1:0] lock_cnt;
  logic           locked_q;
  logic           in_tol;

  assign in_tol = (int'(err) <= LOCK_TOL) && (int'(err) >= -LOCK_TOL);

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_cnt <= '0;
      locked_q <= 1'b0;
    end else if (do_update) begin
      if (in_tol) begin
        if (int'(lock_cnt) < LOCK_CNT)
          lock_cnt <= lock_cnt + 1'b1;
        if (int'(lock_cnt) >= LOCK_CNT - 1)
          locked_q <= 1'b1;
      end else begin
        lock_cnt <= '0;
        locked_q <= 1'b0;
      end
    end
  end

  assign locked = locked_q;
`else
  assign locked = 1'b0;
`endif

endmodule

// File: tb/tb_cp_loop_filter.sv
// tb/tb_cp_loop_filter.sv - self-checking bench for cp_loop_filter

module tb_cp_loop_filter;

  localparam int CTRL_MAX  = 4095;
  localparam int INTEG_MAX = 4095 * 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              up;
  logic              dn;
  logic [11:0]       ctrl;
  logic              ctrl_valid;
  logic signed [7:0] err;
  logic              sat_hi;
  logic              sat_lo;
  logic              locked;

  int errors = 0;
  int checks = 0;

  // window-level reference model
  int m_integ, m_ctrl, m_err, m_lcnt;
  bit m_hi, m_lo, m_locked;

  logic [1:0] pat[$];

  cp_loop_filter dut (
    .clk(clk), .reset(reset), .up(up), .dn(dn),
    .ctrl(ctrl), .ctrl_valid(ctrl_valid), .err(err),
    .sat_hi(sat_hi), .sat_lo(sat_lo), .locked(locked)
  );

  always #5 clk = ~clk;

  function automatic int clip(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_integ = 2048 * 16; m_ctrl = 2048; m_err = 0;
    m_hi = 0; m_lo = 0; m_lcnt = 0; m_locked = 0;
  endtask

  // Apply one window to the model: count, integrate, output, lock.
  task automatic model_window();
    int e, s, d;
    e = 0;
    foreach (pat[i]) begin
      d = (pat[i] == 2'b10) ? 1 : ((pat[i] == 2'b01) ? -1 : 0);
      e = clip(e + d, -127, 127);
    end
    m_err   = e;
    m_integ = clip(m_integ + e, 0, INTEG_MAX);
    s       = m_integ / 16 + e * 4;
    m_ctrl  = clip(s, 0, CTRL_MAX);
    m_hi    = (s > CTRL_MAX);
    m_lo    = (s < 0);
    if (e <= 2 && e >= -2) begin
      m_lcnt = (m_lcnt < 16) ? m_lcnt + 1 : 16;
    end else begin
      m_lcnt = 0;
    end
`ifdef CP_LOCK_DETECT_EN
    m_locked = (m_lcnt >= 16);
`else
    m_locked = 0;
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; up = 1'b0; dn = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // Drive pat one cycle per entry, release, and check the resulting update.
  task automatic run_window(input string tag);
    bit early;
    model_window();
    foreach (pat[i]) begin
      @(negedge clk);
      {up, dn} = pat[i];
    end
    @(negedge clk);
    up = 1'b0; dn = 1'b0;
    early = 0;
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      if (ctrl_valid !== 1'b0) early = 1;
    end
    @(negedge clk);
    check({tag, ".no_early_strobe"}, early, 0);
    check({tag, ".strobe"}, ctrl_valid, 1);
    check({tag, ".err"}, err, m_err);
    check({tag, ".ctrl"}, ctrl, m_ctrl);
    check({tag, ".sat_hi"}, sat_hi, m_hi);
    check({tag, ".sat_lo"}, sat_lo, m_lo);
    check({tag, ".locked"}, locked, m_locked);
    @(negedge clk);
    check({tag, ".strobe_width"}, ctrl_valid, 0);
  endtask

  task automatic fill(input int n, input logic [1:0] v);
    pat.delete();
    for (int i = 0; i < n; i++) pat.push_back(v);
  endtask

  initial begin
    bit seen;
    int at_max, guard;
    reset = 1'b1; up = 1'b0; dn = 1'b0;
    model_reset();

    // reset state
    do_reset();
    check("rst.ctrl", ctrl, 2048);
    check("rst.ctrl_valid", ctrl_valid, 0);
    check("rst.err", err, 0);
    check("rst.sat_hi", sat_hi, 0);
    check("rst.sat_lo", sat_lo, 0);
    check("rst.locked", locked, 0);

    // up 10 cycles -> +10, ctrl 2088
    fill(10, 2'b10);
    run_window("up10");
    check("up10.ctrl_abs", ctrl, 2088);

    // dn 10 cycles from reset -> -10, ctrl 2007
    do_reset();
    fill(10, 2'b01);
    run_window("dn10");
    check("dn10.ctrl_abs", ctrl, 2007);

    // up 6 with dn overlapping last 2 -> +4, ctrl 2064
    do_reset();
    fill(4, 2'b10);
    pat.push_back(2'b11); pat.push_back(2'b11);
    run_window("overlap");
    check("overlap.err_abs", err, 4);
    check("overlap.ctrl_abs", ctrl, 2064);

    // long windows drive ctrl into the upper clamp and the integrator to its cap
    do_reset();
    fill(300, 2'b10);
    run_window("long300");
    check("long300.err_abs", err, 127);
    at_max = 0; guard = 0;
    while (at_max < 2 && guard < 400) begin
      fill(130, 2'b10);
      run_window("satrun");
      if (m_integ == INTEG_MAX) at_max++;
      guard++;
    end
    check("sat.ctrl_abs", ctrl, CTRL_MAX);
    check("sat.sat_hi_abs", sat_hi, 1);
    fill(10, 2'b01);
    run_window("unsat");
    check("unsat.ctrl_abs", ctrl, 4054);

    // lock detector: 16 tiny windows, then one outside tolerance
    do_reset();
    for (int w = 0; w < 16; w++) begin
      fill(1, 2'b10);
      run_window("lock");
    end
    fill(5, 2'b10);
    run_window("unlock");
    check("unlock.locked_abs", locked, 0);

    // reset in the middle of a 20-cycle up pulse discards the window
    do_reset();
    @(negedge clk); up = 1'b1;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    up = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_reset();
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (ctrl_valid !== 1'b0) seen = 1;
    end
    check("midrst.no_strobe", seen, 0);
    check("midrst.ctrl", ctrl, 2048);
    fill(3, 2'b10);
    run_window("after_rst");
    check("after_rst.err_abs", err, 3);

    // randomized windows against the model
    do_reset();
    for (int w = 0; w < 30; w++) begin
      int len;
      len = $urandom_range(1, 24);
      pat.delete();
      for (int i = 0; i < len; i++) pat.push_back(2'($urandom_range(1, 3)));
      run_window("rand");
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cp_loop_filter.md
# cp_loop_filter

Digital charge-pump and PI loop filter for the PLL. It consumes the PFD's `up`/`dn` pulses and measures each pulse pair in `clk` cycles to get a signed phase error. It integrates that error and drives a saturated control word to the digitally controlled oscillator. It also supports an optional lock detector.

## Interface
- `CTRL_W`, 12: control word width (unsigned).
- `PW`, 8: error counter width (signed, PW bits).
- `KP_SHIFT`, 2: proportional gain = 2^KP_SHIFT.
- `KI_SHIFT`, 4: integrator fractional bits; integral gain = 2^-KI_SHIFT.
- `CTRL_INIT`, 2048: control word after reset.
- `LOCK_TOL`, 2: max |err| counted as in-lock.
- `LOCK_CNT`, 16: consecutive in-lock updates needed to assert `locked`.

Ports:
- `clk`  in  1  sole clock, all state on rising edge.
- `reset`  in  1  synchronous, active-high.
- `up`  in  1  PFD up pulse (asynchronous to `clk`); high = raise frequency.
- `dn`  in  1  PFD down pulse (asynchronous); high = lower frequency.
- `ctrl`  out  CTRL_W  DCO control word.
- `ctrl_valid`  out  1  one-cycle strobe when `ctrl` changes.
- `err`  out  PW  signed error of last completed window.
- `sat_hi` / `sat_lo`  out  1 each  last update clamped at max / min.
- `locked`  out  1  lock indicator.

## Operation
- `up`/`dn` pass through a 2-flop synchronizer, giving `up_s`/`dn_s`. All logic below uses the synced signals.
- FSM states are IDLE, MEASURE and UPDATE.
  - IDLE: if `up_s|dn_s`, clear the counter, count this cycle, and go to MEASURE.
  - MEASURE: each cycle, `up_s&~dn_s` adds +1, `dn_s&~up_s` adds -1, and both high adds 0. The first cycle with both low latches the counter into `err` and goes to UPDATE.
  - UPDATE: compute the new `ctrl`, pulse `ctrl_valid`, go to IDLE.
- Counter saturates at ±(2^(PW-1)-1) with no wrap. A window left open indefinitely holds the saturated value.
- Integrator `integ` is unsigned, CTRL_W+KI_SHIFT bits.
  - Reset value: CTRL_INIT<<KI_SHIFT.
  - Update: integ += sext(err), clamped to [0, (2^CTRL_W-1)<<KI_SHIFT] (anti-windup).
- Output: ctrl = clamp(integ_new>>KI_SHIFT + err·2^KP_SHIFT, 0, 2^CTRL_W-1).
  - Intermediates are signed, CTRL_W+KI_SHIFT+2 bits.
  - `sat_hi`/`sat_lo` are set when the respective clamp is taken and cleared otherwise. Both update only in UPDATE.
- Lock detector, evaluated in UPDATE:
  - |err| ≤ LOCK_TOL increments `lock_cnt`, saturating at LOCK_CNT.
  - Otherwise `lock_cnt` and `locked` clear.
  - `locked` rises on the update where `lock_cnt` reaches LOCK_CNT.

## Timing
- Reset values: `ctrl`=CTRL_INIT, `ctrl_valid`=0, `err`=0, `sat_hi`=`sat_lo`=0, `locked`=0, FSM=IDLE, `lock_cnt`=0, synchronizer flops 0.
- `reset` mid-window discards the partial count. No `ctrl_valid` is produced for it.
- Input to `up_s`: 2 cycles.
- First both-low synced cycle (MEASURE, `err` latched) to `ctrl`/`ctrl_valid`: 1 cycle (registered in UPDATE).
- A new pulse arriving during UPDATE is caught in the next IDLE cycle; the at-most-1-cycle loss is acceptable.
- Back-to-back windows need ≥1 both-low cycle between them; otherwise they merge into one window.
- `ctrl` holds between strobes.

## Configuration
- `CP_LOCK_DETECT_EN` defined: lock counter and `locked` are implemented as above.
- Not defined: no lock counter logic; `locked` is tied to 0.

## Structure
- Package `cp_loop_pkg` holds:
  - FSM state enum (IDLE/MEASURE/UPDATE).
  - Default parameter constants.
  - The saturate/clamp function used for the counter, integrator and `ctrl`.
- Sub-module `pfd_sync` is a 2-flop synchronizer instantiated once per input. It has sync reset to 0.

## Test plan
- Reset, then `up` high 10 synced cycles → `err`=+10, integ=32778, `ctrl`=2088, `ctrl_valid` one cycle.
- From reset, `dn` high 10 cycles → `err`=-10, integ=32758, `ctrl`=2007, `sat_lo`=0.
- `up` 6 cycles with `dn` also high in the last 2 → `err`=+4, `ctrl`=2064.
- `up` held 300 cycles → `err`=+127. Repeat until `ctrl`=4095 with `sat_hi`=1; integ stays at 4095<<4 (no windup). A following `dn` 10-cycle pulse lowers `ctrl` immediately.
- With `CP_LOCK_DETECT_EN`: 16 windows of `up` 1 cycle → `locked`=1 on the 16th `ctrl_valid`; then `up` 5 cycles → `locked`=0 at that update.
- Assert `reset` during a 20-cycle `up` pulse → no `ctrl_valid`, `ctrl`=2048, next 3-cycle pulse gives `err`=+3.
